quad_decoder: RTL and testbench

//  Quadrature decoder: synchronises, debounces and decodes a 2-channel encoder (A/B) into single-cycle
//  up/down strobes. Sits directly upstream of the parameterized up/down counter; drives its up/down inputs.

---
 rtl/qdec_pkg.sv | 37 +++
 rtl/qdec_filter.sv | 62 ++++++
 rtl/quad_decoder.sv | 113 +++++++++++
 tb/tb_quad_decoder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// qdec_pkg -- shared types and the quadrature transition lookup for quad_decoder.
//   qphase_t     : filtered phase {A,B}
//   qdec_state_e : decoder FSM states
//   qdir_e       : classification of a phase transition
//   qdec_dir()   : classifies prev -> nxt as none / forward / reverse / illegal
package qdec_pkg;

    typedef logic [1:0] qphase_t;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } qdec_state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_FWD  = 2'd1,
        DIR_REV  = 2'd2,
        DIR_ERR  = 2'd3
    } qdir_e;

    // Forward order is the Gray sequence 00>01>11>10>00, whose successor is
    // {prev[0], ~prev[1]}. Any single-bit change that is not forward is reverse.
    function automatic qdir_e qdec_dir(qphase_t prev, qphase_t nxt);
        qphase_t fwd_next;
        fwd_next = {prev[0], ~prev[1]};
        if (prev == nxt)
            return DIR_NONE;
        else if ((prev ^ nxt) == 2'b11)
            return DIR_ERR;
        else if (nxt == fwd_next)
            return DIR_FWD;
        else
            return DIR_REV;
    endfunction

endpackage

// File: rtl/qdec_filter.sv
// qdec_filter -- one encoder channel: synchroniser, debounce filter, sticky stable flag.
// Ports:
//   clk     system clock
//   rstn    asynchronous active-low reset
//   din     raw channel, asynchronous to clk
//   dout    filtered channel value
//   stable  sticky; set once the debounce counter has sat at zero for FILT_CYCLES cycles
module qdec_filter
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout,
    output logic stable
);

    localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          scnt;
    logic                   s_in;

    assign s_in = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync   <= '0;
            cnt    <= '0;
            scnt   <= '0;
            dout   <= 1'b0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};

            // cnt holds the number of consecutive differing cycles already seen,
            // so the FILT_CYCLES-th one is the cycle where cnt == FILT_CYCLES-1.
            if (s_in == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_CYCLES - 1)) begin
                dout <= s_in;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (!stable) begin
                if (cnt != '0)
                    scnt <= '0;
                else if (scnt == CW'(FILT_CYCLES - 1))
                    stable <= 1'b1;
                else
                    scnt <= scnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder -- synchronises, debounces and decodes a 2-channel quadrature encoder
// into single-cycle up/down strobes for a downstream up/down counter.
// Ports:
//   clk      system clock
//   rstn     asynchronous active-low reset
//   enc_a    encoder channel A (asynchronous)
//   enc_b    encoder channel B (asynchronous)
//   en       strobe enable; phase is tracked even when low
//   up       one-cycle pulse per forward step
//   down     one-cycle pulse per reverse step
//   err      one-cycle pulse per illegal (both-channel) transition
//   phase    current filtered phase {A,B}
//   err_cnt  saturating illegal-transition count (only with QDEC_ERR_CNT_EN)
//   locked   set once the initial phase has been captured
// Build option: define QDEC_ERR_CNT_EN to add the err_cnt counter and port.
//
// state | meaning
// INIT  | waiting for both channels to report stable; no strobes
// TRACK | decoding filtered phase changes into up/down/err strobes
module quad_decoder
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int ERR_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 en,
    output logic                 up,
    output logic                 down,
    output logic                 err,
    output logic [1:0]           phase,
`ifdef QDEC_ERR_CNT_EN
    output logic [ERR_WIDTH-1:0] err_cnt,
`endif
    output logic                 locked
);

    if (ERR_WIDTH < 1) begin : g_err_width_chk
        $error("quad_decoder: ERR_WIDTH must be >= 1");
    end

    logic        filt_a, filt_b;
    logic        stable_a, stable_b;
    qphase_t     nxt;
    qdir_e       dir;
    qdec_state_e state;

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_a (
        .clk    (clk),
        .rstn   (rstn),
        .din    (enc_a),
        .dout   (filt_a),
        .stable (stable_a)
    );

    qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_b (
        .clk    (clk),
        .rstn   (rstn),
        .din    (enc_b),
        .dout   (filt_b),
        .stable (stable_b)
    );

    assign nxt = {filt_a, filt_b};
    assign dir = qdec_dir(phase, nxt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= INIT;
            phase  <= 2'b00;
            locked <= 1'b0;
            up     <= 1'b0;
            down   <= 1'b0;
            err    <= 1'b0;
        end else begin
            up   <= 1'b0;
            down <= 1'b0;
            err  <= 1'b0;
            case (state)
                INIT: begin
                    if (stable_a && stable_b) begin
                        phase  <= nxt;
                        locked <= 1'b1;
                        state  <= TRACK;
                    end
                end
                TRACK: begin
                    // The enum decode makes up/down/err mutually exclusive by construction.
                    up   <= en && (dir == DIR_FWD);
                    down <= en && (dir == DIR_REV);
                    err  <= (dir == DIR_ERR);
                    if (dir != DIR_NONE)
                        phase <= nxt;
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef QDEC_ERR_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_cnt <= '0;
        else if (err && (err_cnt != '1))
            err_cnt <= err_cnt + ERR_WIDTH'(1);
    end
`endif

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rstn;
    logic       enc_a, enc_b, en;
    logic       up, down, err, locked;
    logic [1:0] phase;
`ifdef QDEC_ERR_CNT_EN
    logic [1:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    int t, n_up, n_dn, n_err, first_up, first_dn, first_err, excl;

    always #5 clk = ~clk;

    quad_decoder #(.SYNC_STAGES(2), .FILT_CYCLES(4), .ERR_WIDTH(2)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .en      (en),
        .up      (up),
        .down    (down),
        .err     (err),
        .phase   (phase),
`ifdef QDEC_ERR_CNT_EN
        .err_cnt (err_cnt),
`endif
        .locked  (locked)
    );

    typedef struct {
        logic       a;
        logic       b;
        logic       en;
        int         n_up;
        int         n_dn;
        int         n_err;
        logic [1:0] ph;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        t = 0; n_up = 0; n_dn = 0; n_err = 0;
        first_up = 0; first_dn = 0; first_err = 0; excl = 0;
    endtask

    task automatic mon(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            t++;
            if (up)   begin n_up++;  if (first_up  == 0) first_up  = t; end
            if (down) begin n_dn++;  if (first_dn  == 0) first_dn  = t; end
            if (err)  begin n_err++; if (first_err == 0) first_err = t; end
            if (int'(up) + int'(down) + int'(err) > 1) excl++;
        end
    endtask

    initial begin
        // step table: each held 20 cycles; any strobe must land 7 cycles after the pin edge
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1, 0, 0, 2'b10};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1, 0, 0, 2'b00};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1, 0, 0, 2'b01};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1, 0, 0, 2'b11};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1, 0, 0, 2'b10};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1, 0, 0, 2'b00};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 0, 1, 0, 2'b10};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 0, 1, 0, 2'b11};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 2'b01};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 2'b00};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 0, 1, 0, 2'b10};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 0, 1, 0, 2'b11};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 0, 1, 0, 2'b01};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 0, 1, 0, 2'b00};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 0, 0, 1, 2'b11};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 2'b00};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 0, 0, 1, 2'b11};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 0, 0, 1, 2'b00};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 0, 0, 1, 2'b11};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 0, 1, 0, 2'b01};

        // reset release with A=B=1
        rstn = 1'b0; enc_a = 1'b1; enc_b = 1'b1; en = 1'b1;
        tick(); tick(); tick();
        check("rst_locked", int'(locked), 0);
        check("rst_phase", int'(phase), 0);
        rstn = 1'b1;
        clr();
        mon(10);
        check("lock_early", int'(locked), 0);
        mon(5);
        check("lock_late", int'(locked), 1);
        check("lock_phase", int'(phase), 3);
        check("lock_strobes", n_up + n_dn + n_err, 0);

        for (int v = 0; v < 20; v++) begin
            enc_a = vecs[v].a; enc_b = vecs[v].b; en = vecs[v].en;
            clr();
            mon(20);
            check($sformatf("v%0d_up", v), n_up, vecs[v].n_up);
            check($sformatf("v%0d_down", v), n_dn, vecs[v].n_dn);
            check($sformatf("v%0d_err", v), n_err, vecs[v].n_err);
            check($sformatf("v%0d_phase", v), int'(phase), int'(vecs[v].ph));
            check($sformatf("v%0d_excl", v), excl, 0);
            if (vecs[v].n_up > 0)  check($sformatf("v%0d_up_lat", v), first_up, 7);
            if (vecs[v].n_dn > 0)  check($sformatf("v%0d_dn_lat", v), first_dn, 7);
            if (vecs[v].n_err > 0) check($sformatf("v%0d_err_lat", v), first_err, 7);
        end
`ifdef QDEC_ERR_CNT_EN
        check("err_cnt_sat", int'(err_cnt), 3);
`endif

        // 3-cycle glitch on A from phase 01: filtered out
        en = 1'b1;
        clr();
        enc_a = 1'b1;
        mon(3);
        enc_a = 1'b0;
        mon(20);
        check("g3_strobes", n_up + n_dn + n_err, 0);
        check("g3_phase", int'(phase), 1);

        // 4-cycle glitch on A from phase 01: forward to 11 then back to 01
        clr();
        enc_a = 1'b1;
        mon(4);
        enc_a = 1'b0;
        mon(20);
        check("g4_up", n_up, 1);
        check("g4_down", n_dn, 1);
        check("g4_err", n_err, 0);
        check("g4_up_at", first_up, 7);
        check("g4_dn_at", first_dn, 11);
        check("g4_phase", int'(phase), 1);

        // reset 3 cycles into a pending filter count
        clr();
        enc_a = 1'b1;
        mon(3);
        rstn = 1'b0;
        #1;
        check("mid_rst_up", int'(up), 0);
        check("mid_rst_down", int'(down), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_phase", int'(phase), 0);
`ifdef QDEC_ERR_CNT_EN
        check("mid_rst_err_cnt", int'(err_cnt), 0);
`endif
        check("mid_rst_pre_strobes", n_up + n_dn + n_err, 0);
        tick(); tick(); tick();
        enc_b = 1'b1;
        rstn = 1'b1;
        clr();
        mon(10);
        check("relock_early", int'(locked), 0);
        mon(10);
        check("relock_late", int'(locked), 1);
        check("relock_phase", int'(phase), 3);
        check("relock_strobes", n_up + n_dn + n_err, 0);

        // first step after re-lock still decodes
        clr();
        enc_b = 1'b0;
        mon(20);
        check("post_relock_up", n_up, 1);
        check("post_relock_up_at", first_up, 7);
        check("post_relock_phase", int'(phase), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
